mac_prog_sequencer: RTL and testbench

// - Upstream feeder for the tt_um_mac core: captures a program of {instr, operand} byte pairs from
//   the pads, then replays it to the MAC core over a valid/ready issue port, once or looped.
// - Decouples slow pad-rate program entry from back-to-back, one-pair-per-cycle execution.

---
 rtl/mac_pkg.sv | 18 +
 rtl/mac_prog_mem.sv | 27 ++
 rtl/mac_prog_sequencer.sv | 150 +++++++++++++++
 tb/tb_mac_prog_sequencer.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared definitions for the MAC core and its program sequencer: opcodes,
// sequencer state encoding and the width of one issued {instr, operand} pair.
package mac_pkg;

   localparam logic [1:0] OP_NOP  = 2'b00;
   localparam logic [1:0] OP_LOAD = 2'b01;
   localparam logic [1:0] OP_MAC  = 2'b10;
   localparam logic [1:0] OP_OUT  = 2'b11;

   localparam int ISSUE_W = 16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } seq_state_t;

endpackage

// File: rtl/mac_prog_mem.sv
// Program store for the sequencer: DEPTH x ISSUE_W register file with one
// synchronous write port and one combinational read port; contents survive reset.
module mac_prog_mem
   import mac_pkg::*;
#(
   parameter int DEPTH  = 8,
   parameter int ADDR_W = 3
) (
   input  logic               clk,
   input  logic               we,
   input  logic [ADDR_W-1:0]  waddr,
   input  logic [ISSUE_W-1:0] wdata,
   input  logic [ADDR_W-1:0]  raddr,
   output logic [ISSUE_W-1:0] rdata
);

   logic [ISSUE_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/mac_prog_sequencer.sv
// Captures a short {instr, operand} program at pad rate and replays it to the
// MAC core over a valid/ready port at one pair per cycle, once or looped.
module mac_prog_sequencer
   import mac_pkg::*;
#(
   parameter int DEPTH  = 8,
   parameter int ADDR_W = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ena,
   input  logic              wr_en,
   input  logic [7:0]        wr_instr,
   input  logic [7:0]        wr_data,
   input  logic              clear,
   input  logic              start,
   input  logic              loop_en,
   input  logic              abort,
   output logic              issue_valid,
   input  logic              issue_ready,
   output logic [7:0]        issue_instr,
   output logic [7:0]        issue_data,
   output logic [ADDR_W:0]   prog_len,
   output logic              full,
   output logic              overflow,
   output logic              done,
   output logic [1:0]        state_dbg
);

   localparam logic [ADDR_W:0]   LEN_ONE  = (ADDR_W+1)'(1);
   localparam logic [ADDR_W:0]   LEN_FULL = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] RP_ONE   = ADDR_W'(1);

   seq_state_t         state_q, state_d;
   logic [ADDR_W:0]    len_q, len_d;
   logic [ADDR_W-1:0]  rp_q, rp_d;
   logic               valid_q, valid_d;
   logic [ISSUE_W-1:0] pair_q, pair_d;
   logic               ovf_q, ovf_d;
   logic               mem_we;
   logic               last;
   logic [ADDR_W-1:0]  rd_addr;
   logic [ISSUE_W-1:0] rd_data;

   // The single read port always points at the pair that would be issued
   // next: entry 0 when starting or wrapping, otherwise rp+1.
   assign last    = ({1'b0, rp_q} == (len_q - LEN_ONE));
   assign rd_addr = (state_q == ST_RUN && !last) ? (rp_q + RP_ONE) : '0;
   assign full    = (len_q == LEN_FULL);

   mac_prog_mem #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_mem (
      .clk   (clk),
      .we    (mem_we & ena),
      .waddr (len_q[ADDR_W-1:0]),
      .wdata ({wr_instr, wr_data}),
      .raddr (rd_addr),
      .rdata (rd_data)
   );

   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      rp_d    = rp_q;
      valid_d = valid_q;
      pair_d  = pair_q;
      ovf_d   = ovf_q;
      mem_we  = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            // Priority abort > clear > start > wr_en; losers are simply dropped.
            if (abort) begin
               valid_d = 1'b0;
            end else if (clear) begin
               len_d = '0;
               ovf_d = 1'b0;
            end else if (start) begin
               if (len_q != '0) begin
                  state_d = ST_RUN;
                  pair_d  = rd_data;
                  valid_d = 1'b1;
                  rp_d    = '0;
               end
            end else if (wr_en) begin
               if (full) begin
                  ovf_d = 1'b1;
               end else begin
                  mem_we = 1'b1;
                  len_d  = len_q + LEN_ONE;
               end
            end
         end
         ST_RUN: begin
            if (abort) begin
               state_d = ST_IDLE;
               valid_d = 1'b0;
            end else if (valid_q && issue_ready) begin
               if (!last) begin
                  rp_d   = rp_q + RP_ONE;
                  pair_d = rd_data;
               end else if (loop_en) begin
                  rp_d   = '0;
                  pair_d = rd_data;
               end else begin
                  valid_d = 1'b0;
                  state_d = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
         end
         default: begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         len_q   <= '0;
         rp_q    <= '0;
         valid_q <= 1'b0;
         pair_q  <= '0;
         ovf_q   <= 1'b0;
      end else if (ena) begin
         state_q <= state_d;
         len_q   <= len_d;
         rp_q    <= rp_d;
         valid_q <= valid_d;
         pair_q  <= pair_d;
         ovf_q   <= ovf_d;
      end
   end

   // Masking valid with ena keeps the core from seeing a handshake while frozen.
   assign issue_valid = valid_q & ena;
   assign issue_instr = pair_q[15:8];
   assign issue_data  = pair_q[7:0];
   assign prog_len    = len_q;
   assign overflow    = ovf_q;
   assign done        = (state_q == ST_DONE);
   assign state_dbg   = state_q;

endmodule

// File: tb/tb_mac_prog_sequencer.sv
// Scoreboard bench for mac_prog_sequencer: expected pairs are queued at start
// and popped by a negedge monitor on every accepted handshake.
module tb_mac_prog_sequencer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       ena;
   logic       wr_en;
   logic [7:0] wr_instr;
   logic [7:0] wr_data;
   logic       clear;
   logic       start;
   logic       loop_en;
   logic       abort;
   logic       issue_valid;
   logic       issue_ready;
   logic [7:0] issue_instr;
   logic [7:0] issue_data;
   logic [3:0] prog_len;
   logic       full;
   logic       overflow;
   logic       done;
   logic [1:0] state_dbg;

   int          num_checks = 0;
   int          num_errors = 0;
   int          accepts    = 0;
   int          done_count = 0;
   logic [15:0] sb [$];
   logic [15:0] prog [$];
   logic        hold_pend  = 1'b0;
   logic [15:0] hold_pair  = '0;

   mac_prog_sequencer #(.DEPTH(8), .ADDR_W(3)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .ena         (ena),
      .wr_en       (wr_en),
      .wr_instr    (wr_instr),
      .wr_data     (wr_data),
      .clear       (clear),
      .start       (start),
      .loop_en     (loop_en),
      .abort       (abort),
      .issue_valid (issue_valid),
      .issue_ready (issue_ready),
      .issue_instr (issue_instr),
      .issue_data  (issue_data),
      .prog_len    (prog_len),
      .full        (full),
      .overflow    (overflow),
      .done        (done),
      .state_dbg   (state_dbg)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      num_checks++;
      if (got !== exp) begin
         num_errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Accepted pairs are checked against the scoreboard; stalled pairs must hold.
   always @(negedge clk) begin
      if (rst_n) begin
         if (hold_pend && issue_valid)
            checkOutput("hold", {issue_instr, issue_data}, hold_pair);
         hold_pend = issue_valid && !issue_ready;
         hold_pair = {issue_instr, issue_data};
         if (issue_valid && issue_ready && !abort) begin
            if (sb.size() == 0) begin
               checkOutput("sb_underflow", {issue_instr, issue_data}, 32'hFFFF_FFFF);
            end else begin
               checkOutput("pair", {issue_instr, issue_data}, sb.pop_front());
            end
            accepts++;
         end
         if (done) done_count++;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [7:0] instr, input logic [7:0] data);
      wr_en    = 1'b1;
      wr_instr = instr;
      wr_data  = data;
      tick();
      wr_en    = 1'b0;
      if (prog.size() < 8) prog.push_back({instr, data});
   endtask

   task automatic clearProgram();
      clear = 1'b1;
      tick();
      clear = 1'b0;
      prog.delete();
   endtask

   task automatic startRun(input int n);
      for (int i = 0; i < n; i++) sb.push_back(prog[i % prog.size()]);
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic waitDone(input int bound, output int cycles);
      cycles = 0;
      while (done !== 1'b1 && cycles < bound) begin
         tick();
         cycles++;
      end
      if (done !== 1'b1) checkOutput("done_timeout", 0, 1);
      else checkOutput("state_done", state_dbg, 2);
   endtask

   int cyc;
   int acc0;
   int dc0;

   initial begin
      rst_n = 1'b0; ena = 1'b1; wr_en = 1'b0; wr_instr = '0; wr_data = '0;
      clear = 1'b0; start = 1'b0; loop_en = 1'b0; abort = 1'b0; issue_ready = 1'b0;
      #23 rst_n = 1'b1;
      tick();

      checkOutput("rst_valid", issue_valid, 0);
      checkOutput("rst_len", prog_len, 0);
      checkOutput("rst_state", state_dbg, 0);
      checkOutput("rst_ovf", overflow, 0);
      checkOutput("rst_done", done, 0);
      checkOutput("rst_issue", {issue_instr, issue_data}, 16'h0000);

      // Straight pass, ready always high
      applyStimulus(8'h41, 8'hFF); applyStimulus(8'h42, 8'hAA); applyStimulus(8'h81, 8'h55);
      applyStimulus(8'hC0, 8'h22); applyStimulus(8'h44, 8'h33);
      checkOutput("len5", prog_len, 5);
      issue_ready = 1'b1;
      dc0 = done_count;
      startRun(5);
      checkOutput("state_run", state_dbg, 1);
      waitDone(20, cyc);
      checkOutput("pass_cycles", cyc, 5);
      tick();
      checkOutput("state_idle", state_dbg, 0);
      checkOutput("done_once", done_count - dc0, 1);
      checkOutput("sb_empty1", sb.size(), 0);

      // Back-pressured pass
      dc0 = done_count;
      acc0 = accepts;
      issue_ready = 1'b1;
      startRun(5);
      cyc = 0;
      while (done !== 1'b1 && cyc < 40) begin
         issue_ready = (cyc % 3 == 0);
         tick();
         cyc++;
      end
      checkOutput("bp_done", done, 1);
      checkOutput("bp_accepts", accepts - acc0, 5);
      tick();
      checkOutput("bp_done_once", done_count - dc0, 1);
      checkOutput("sb_empty2", sb.size(), 0);

      // Overflow and clear
      issue_ready = 1'b1;
      clearProgram();
      for (int i = 0; i < 9; i++) applyStimulus(8'h10 + 8'(i), 8'hA0 + 8'(i));
      checkOutput("len8", prog_len, 8);
      checkOutput("full", full, 1);
      checkOutput("ovf", overflow, 1);
      acc0 = accepts;
      startRun(8);
      waitDone(20, cyc);
      tick();
      checkOutput("full_accepts", accepts - acc0, 8);
      checkOutput("sb_empty3", sb.size(), 0);
      clearProgram();
      checkOutput("clr_len", prog_len, 0);
      checkOutput("clr_ovf", overflow, 0);
      checkOutput("clr_full", full, 0);

      // Looped replay
      applyStimulus(8'h41, 8'h01); applyStimulus(8'h81, 8'h02); applyStimulus(8'hC0, 8'h03);
      loop_en = 1'b1;
      dc0 = done_count;
      acc0 = accepts;
      startRun(7);
      for (int i = 0; i < 7; i++) tick();
      checkOutput("loop_accepts", accepts - acc0, 7);
      checkOutput("loop_no_done", done_count - dc0, 0);
      checkOutput("loop_state", state_dbg, 1);
      loop_en = 1'b0;
      sb.push_back(prog[1]);
      sb.push_back(prog[2]);
      waitDone(10, cyc);
      checkOutput("loop_tail", cyc, 2);
      tick();
      checkOutput("sb_empty4", sb.size(), 0);

      // Abort during second pair
      dc0 = done_count;
      startRun(3);
      tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      checkOutput("abort_valid", issue_valid, 0);
      checkOutput("abort_state", state_dbg, 0);
      checkOutput("abort_len", prog_len, 3);
      checkOutput("abort_left", sb.size(), 2);
      sb.delete();
      tick();
      checkOutput("abort_no_done", done_count - dc0, 0);
      startRun(3);
      checkOutput("replay_state", state_dbg, 1);
      waitDone(10, cyc);
      checkOutput("replay_cycles", cyc, 3);
      tick();
      checkOutput("sb_empty5", sb.size(), 0);

      // Asynchronous reset mid-run
      issue_ready = 1'b0;
      startRun(3);
      tick();
      #1 rst_n = 1'b0;
      #1;
      checkOutput("arst_valid", issue_valid, 0);
      checkOutput("arst_len", prog_len, 0);
      checkOutput("arst_state", state_dbg, 0);
      rst_n = 1'b1;
      sb.delete();
      prog.delete();
      tick();
      issue_ready = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      checkOutput("empty_start_state", state_dbg, 0);
      checkOutput("empty_start_valid", issue_valid, 0);

      // Enable freeze mid-run
      applyStimulus(8'h41, 8'h01); applyStimulus(8'h81, 8'h02); applyStimulus(8'hC0, 8'h03);
      acc0 = accepts;
      startRun(3);
      tick();
      ena = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         checkOutput("ena_valid", issue_valid, 0);
         checkOutput("ena_state", state_dbg, 1);
      end
      checkOutput("ena_accepts", accepts - acc0, 1);
      ena = 1'b1;
      waitDone(10, cyc);
      checkOutput("ena_resume", cyc, 2);
      tick();
      checkOutput("sb_empty6", sb.size(), 0);
      checkOutput("ena_total", accepts - acc0, 3);

      $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
      $finish;
   end

endmodule
